// File: rtl/calendar_bcd_clock.sv
// BCD time-of-day and 2000-2099 calendar with leap years, validated synchronous load,
// day/month/year rollover pulses and an optional en_s-qualified second prescaler.
module calendar_bcd_clock #(
  parameter int TICK_DIV = 1,
  parameter bit LEAP_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_s,
  input  logic       load,
  input  logic [7:0] ld_sec,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_hour,
  input  logic [7:0] ld_day,
  input  logic [7:0] ld_mon,
  input  logic [7:0] ld_year,
  output logic [3:0] sec_unit,
  output logic [3:0] sec_ten,
  output logic [3:0] min_unit,
  output logic [3:0] min_ten,
  output logic [3:0] hour_unit,
  output logic [3:0] hour_ten,
  output logic [3:0] day_unit,
  output logic [1:0] day_ten,
  output logic [3:0] mon_unit,
  output logic       mon_ten,
  output logic [3:0] year_unit,
  output logic [3:0] year_ten,
  output logic       pulse_day,
  output logic       pulse_month,
  output logic       pulse_year,
  output logic       load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pcnt;
  logic [7:0]    sec_q, min_q, hour_q, year_q;
  logic [5:0]    day_q;
  logic [4:0]    mon_q;

  logic [7:0]    sec_n, min_n, hour_n, year_n;
  logic [5:0]    day_n, day_inc;
  logic [4:0]    mon_n, mon_inc;
  logic          tick, pd_n, pm_n, py_n, ld_ok;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Leap test works directly on the BCD digits: year%4==0 for 00-99.
  function automatic logic is_leap(input logic [7:0] y);
    logic [3:0] u;
    u = y[3:0];
    return LEAP_EN && ((!y[4] && (u == 4'd0 || u == 4'd4 || u == 4'd8)) ||
                       ( y[4] && (u == 4'd2 || u == 4'd6)));
  endfunction

  function automatic logic [5:0] month_len(input logic [4:0] m, input logic [7:0] y);
    case (m)
      5'h01, 5'h03, 5'h05, 5'h07, 5'h08, 5'h10, 5'h12: return 6'h31;
      5'h02:                                            return is_leap(y) ? 6'h29 : 6'h28;
      default:                                          return 6'h30;
    endcase
  endfunction

  always_comb begin
    if (TICK_DIV == 1) tick = en_s;
    else               tick = en_s && (pcnt == PW'(TICK_DIV - 1));
  end

  always_comb begin
    ld_ok = bcd_ok(ld_sec)  && (ld_sec  <= 8'h59) &&
            bcd_ok(ld_min)  && (ld_min  <= 8'h59) &&
            bcd_ok(ld_hour) && (ld_hour <= 8'h23) &&
            bcd_ok(ld_year) &&
            bcd_ok(ld_mon)  && (ld_mon  >= 8'h01) && (ld_mon <= 8'h12) &&
            bcd_ok(ld_day)  && (ld_day  >= 8'h01) &&
            (ld_day <= {2'b00, month_len(ld_mon[4:0], ld_year)});
  end

  assign day_inc = (day_q[3:0] == 4'd9) ? {day_q[5:4] + 2'd1, 4'd0} : {day_q[5:4], day_q[3:0] + 4'd1};
  assign mon_inc = (mon_q[3:0] == 4'd9) ? 5'h10 : {mon_q[4], mon_q[3:0] + 4'd1};

  // Full carry chain resolves in one edge; each pulse marks the wrap of its field.
  always_comb begin
    sec_n  = sec_q;
    min_n  = min_q;
    hour_n = hour_q;
    day_n  = day_q;
    mon_n  = mon_q;
    year_n = year_q;
    pd_n   = 1'b0;
    pm_n   = 1'b0;
    py_n   = 1'b0;
    if (tick) begin
      sec_n = (sec_q == 8'h59) ? 8'h00 : bcd_inc(sec_q);
      if (sec_q == 8'h59) begin
        min_n = (min_q == 8'h59) ? 8'h00 : bcd_inc(min_q);
        if (min_q == 8'h59) begin
          hour_n = (hour_q == 8'h23) ? 8'h00 : bcd_inc(hour_q);
          if (hour_q == 8'h23) begin
            pd_n = 1'b1;
            if (day_q == month_len(mon_q, year_q)) begin
              day_n = 6'h01;
              pm_n  = 1'b1;
              if (mon_q == 5'h12) begin
                mon_n  = 5'h01;
                py_n   = 1'b1;
                year_n = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
              end else begin
                mon_n = mon_inc;
              end
            end else begin
              day_n = day_inc;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt        <= '0;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= 8'h00;
      day_q       <= 6'h01;
      mon_q       <= 5'h01;
      year_q      <= 8'h00;
      pulse_day   <= 1'b0;
      pulse_month <= 1'b0;
      pulse_year  <= 1'b0;
      load_err    <= 1'b0;
    end else if (load && ld_ok) begin
      // A valid load discards any tick due this edge and restarts the second.
      pcnt        <= '0;
      sec_q       <= ld_sec;
      min_q       <= ld_min;
      hour_q      <= ld_hour;
      day_q       <= ld_day[5:0];
      mon_q       <= ld_mon[4:0];
      year_q      <= ld_year;
      pulse_day   <= 1'b0;
      pulse_month <= 1'b0;
      pulse_year  <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      if (en_s) pcnt <= tick ? '0 : pcnt + PW'(1);
      sec_q       <= sec_n;
      min_q       <= min_n;
      hour_q      <= hour_n;
      day_q       <= day_n;
      mon_q       <= mon_n;
      year_q      <= year_n;
      pulse_day   <= pd_n;
      pulse_month <= pm_n;
      pulse_year  <= py_n;
      load_err    <= load;
    end
  end

  assign sec_unit  = sec_q[3:0];
  assign sec_ten   = sec_q[7:4];
  assign min_unit  = min_q[3:0];
  assign min_ten   = min_q[7:4];
  assign hour_unit = hour_q[3:0];
  assign hour_ten  = hour_q[7:4];
  assign day_unit  = day_q[3:0];
  assign day_ten   = day_q[5:4];
  assign mon_unit  = mon_q[3:0];
  assign mon_ten   = mon_q[4];
  assign year_unit = year_q[3:0];
  assign year_ten  = year_q[7:4];

endmodule

// File: tb/tb_calendar_bcd_clock.sv
// Directed scoreboard bench for calendar_bcd_clock: three instances share stimulus
// (0: TICK_DIV=1 leap, 1: TICK_DIV=1 no-leap, 2: TICK_DIV=4 leap).
module tb_calendar_bcd_clock;

  logic       clk = 1'b0;
  logic       rst, en_s, load;
  logic [7:0] ld_sec, ld_min, ld_hour, ld_day, ld_mon, ld_year;

  logic [47:0] obs_t [3];
  logic [3:0]  obs_f [3];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          dut;
    string       tag;
    logic [47:0] t;
    logic [3:0]  f;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [3:0] su, st, mu, mt, hu, ht, du, mou, yu, yt;
    logic [1:0] dt;
    logic       mot, pd, pm, py, le;

    calendar_bcd_clock #(
      .TICK_DIV ((g == 2) ? 4 : 1),
      .LEAP_EN  ((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en_s        (en_s),
      .load        (load),
      .ld_sec      (ld_sec),
      .ld_min      (ld_min),
      .ld_hour     (ld_hour),
      .ld_day      (ld_day),
      .ld_mon      (ld_mon),
      .ld_year     (ld_year),
      .sec_unit    (su),
      .sec_ten     (st),
      .min_unit    (mu),
      .min_ten     (mt),
      .hour_unit   (hu),
      .hour_ten    (ht),
      .day_unit    (du),
      .day_ten     (dt),
      .mon_unit    (mou),
      .mon_ten     (mot),
      .year_unit   (yu),
      .year_ten    (yt),
      .pulse_day   (pd),
      .pulse_month (pm),
      .pulse_year  (py),
      .load_err    (le)
    );

    assign obs_t[g] = {yt, yu, 3'b000, mot, mou, 2'b00, dt, du, ht, hu, mt, mu, st, su};
    assign obs_f[g] = {py, pm, pd, le};
  end

  // Flag nibble: {pulse_year, pulse_month, pulse_day, load_err}
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_DAY  = 4'b0010;
  localparam logic [3:0] F_MON  = 4'b0110;
  localparam logic [3:0] F_ALL  = 4'b1110;
  localparam logic [3:0] F_ERR  = 4'b0001;

  function automatic logic [47:0] dtv(input logic [7:0] y, mo, d, h, mi, s);
    return {y, mo, d, h, mi, s};
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic expect_v(input int d, input string tag, input logic [47:0] t, input logic [3:0] f);
    exp_t e;
    e.dut = d;
    e.tag = tag;
    e.t   = t;
    e.f   = f;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs_t[e.dut] === e.t && obs_f[e.dut] === e.f)
      else begin
        failures++;
        $error("FAIL %s dut%0d observed=%h/%b expected=%h/%b",
               e.tag, e.dut, obs_t[e.dut], obs_f[e.dut], e.t, e.f);
      end
    end
  endtask

  task automatic set_load(input logic [7:0] y, mo, d, h, mi, s);
    load    = 1'b1;
    ld_year = y;
    ld_mon  = mo;
    ld_day  = d;
    ld_hour = h;
    ld_min  = mi;
    ld_sec  = s;
  endtask

  localparam logic [47:0] RST_V = 48'h00_01_01_00_00_00;

  initial begin
    rst = 1'b1; en_s = 1'b0; load = 1'b0;
    ld_sec = '0; ld_min = '0; ld_hour = '0; ld_day = '0; ld_mon = '0; ld_year = '0;
    for (int d = 0; d < 3; d++) expect_v(d, "reset", RST_V, F_NONE);
    cycle();
    rst = 1'b0;

    // One minute of seconds; the divide-by-4 instance reaches 15 s meanwhile.
    en_s = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      expect_v(0, "count60", dtv(8'h00, 8'h01, 8'h01, 8'h00, to_bcd(i / 60), to_bcd(i % 60)), F_NONE);
      if (i == 60) begin
        expect_v(1, "count60_b", dtv(8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00), F_NONE);
        expect_v(2, "count60_div4", dtv(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h15), F_NONE);
      end
      cycle();
    end
    en_s = 1'b0;

    // Feb 28 of a leap year, leap and non-leap builds.
    set_load(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    for (int d = 0; d < 3; d++) expect_v(d, "load_feb28", dtv(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59), F_NONE);
    cycle();
    load = 1'b0;
    en_s = 1'b1;
    expect_v(0, "leap_feb29", dtv(8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00), F_DAY);
    expect_v(1, "noleap_mar01", dtv(8'h24, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00), F_MON);
    expect_v(2, "div4_no_tick", dtv(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59), F_NONE);
    cycle();
    en_s = 1'b0;
    expect_v(0, "pulse_one_cycle", dtv(8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00), F_NONE);
    cycle();

    // Feb 29 is legal only with leap years enabled.
    set_load(8'h24, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59);
    expect_v(0, "load_feb29", dtv(8'h24, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59), F_NONE);
    expect_v(1, "noleap_feb29_err", dtv(8'h24, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00), F_ERR);
    cycle();
    load = 1'b0;
    en_s = 1'b1;
    expect_v(0, "leap_mar01", dtv(8'h24, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00), F_MON);
    cycle();
    en_s = 1'b0;

    set_load(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    expect_v(0, "load_23feb28", dtv(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59), F_NONE);
    cycle();
    load = 1'b0;
    en_s = 1'b1;
    expect_v(0, "nonleap_yr_mar01", dtv(8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00), F_MON);
    cycle();
    en_s = 1'b0;

    // Century wrap.
    set_load(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    expect_v(0, "load_99dec31", dtv(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59), F_NONE);
    cycle();
    load = 1'b0;
    en_s = 1'b1;
    expect_v(0, "year_wrap", RST_V, F_ALL);
    expect_v(1, "year_wrap_b", RST_V, F_ALL);
    cycle();
    en_s = 1'b0;
    expect_v(0, "year_pulse_clear", RST_V, F_NONE);
    cycle();

    // Rejected loads leave state alone.
    set_load(8'h00, 8'h04, 8'h31, 8'h00, 8'h00, 8'h00);
    expect_v(0, "err_apr31", RST_V, F_ERR);
    cycle();
    set_load(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h5A);
    expect_v(0, "err_sec5a", RST_V, F_ERR);
    cycle();
    set_load(8'h00, 8'h01, 8'h01, 8'h24, 8'h00, 8'h00);
    expect_v(0, "err_hour24", RST_V, F_ERR);
    cycle();
    set_load(8'h00, 8'h13, 8'h01, 8'h00, 8'h00, 8'h00);
    en_s = 1'b1;
    expect_v(0, "err_mon13_tick", dtv(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01), F_ERR);
    cycle();
    load = 1'b0;
    en_s = 1'b0;
    expect_v(0, "err_clear", dtv(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01), F_NONE);
    cycle();

    // Prescaler behaviour on the divide-by-4 instance.
    rst = 1'b1;
    expect_v(2, "div4_reset", RST_V, F_NONE);
    cycle();
    rst = 1'b0;
    en_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_v(2, "div4_wait", RST_V, F_NONE);
      cycle();
    end
    expect_v(2, "div4_step", dtv(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01), F_NONE);
    cycle();
    en_s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_v(2, "div4_frozen", dtv(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01), F_NONE);
      cycle();
    end
    en_s = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_v(2, "div4_pcnt2", dtv(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01), F_NONE);
      cycle();
    end
    set_load(8'h24, 8'h05, 8'h17, 8'h12, 8'h34, 8'h50);
    expect_v(2, "div4_load", dtv(8'h24, 8'h05, 8'h17, 8'h12, 8'h34, 8'h50), F_NONE);
    cycle();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_v(2, "div4_restart", dtv(8'h24, 8'h05, 8'h17, 8'h12, 8'h34, 8'h50), F_NONE);
      cycle();
    end
    expect_v(2, "div4_after_load", dtv(8'h24, 8'h05, 8'h17, 8'h12, 8'h34, 8'h51), F_NONE);
    cycle();
    for (int i = 0; i < 2; i++) cycle();

    // Reset beats a simultaneous valid load.
    rst = 1'b1;
    set_load(8'h24, 8'h05, 8'h17, 8'h12, 8'h34, 8'h50);
    expect_v(2, "rst_over_load", RST_V, F_NONE);
    expect_v(0, "rst_over_load_a", RST_V, F_NONE);
    cycle();
    rst = 1'b0;
    load = 1'b0;
    en_s = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
